// File: rtl/gumnut_bus_pkg.sv
// Shared Gumnut bus definitions: default widths and the data-memory responder state type.
package gumnut_bus_pkg;
    localparam int GUMNUT_ADDR_W = 8;
    localparam int GUMNUT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } resp_state_t;
endpackage

// File: rtl/gumnut_sp_ram.sv
// Single-port synchronous RAM with read-before-write; contents are never reset.
module gumnut_sp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  adr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[adr];
            if (we) mem[adr] <= din;
        end
    end
endmodule

// File: rtl/gumnut_data_mem_responder.sv
// Gumnut data-memory bus responder: latches a request, waits WAIT_STATES cycles,
// accesses the RAM on the edge entering ACK and acknowledges for one cycle.
module gumnut_data_mem_responder
    import gumnut_bus_pkg::*;
#(
    parameter int ADDR_W      = GUMNUT_ADDR_W,
    parameter int DATA_W      = GUMNUT_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_cyc_i,
    input  logic              data_stb_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_adr_i,
    input  logic [DATA_W-1:0] data_dat_i,
    output logic [DATA_W-1:0] data_dat_o,
    output logic              data_ack_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_state_t       state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] lat_adr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_dat;
    logic              req, accept;
    logic [ADDR_W-1:0] acc_adr;
    logic              acc_we;
    logic [DATA_W-1:0] acc_dat;
    logic              in_range, commit, ram_en;
    logic              rd_zero;
    logic [DATA_W-1:0] ram_dout;

    assign req    = data_cyc_i & data_stb_i;
    assign accept = (state == IDLE) & req;

    // With zero wait states the access edge is the acceptance edge, so use the live request.
    assign acc_adr = (state == IDLE) ? data_adr_i : lat_adr;
    assign acc_we  = (state == IDLE) ? data_we_i  : lat_we;
    assign acc_dat = (state == IDLE) ? data_dat_i : lat_dat;

    assign in_range = (32'(acc_adr) < DEPTH);
    assign commit   = (state_nxt == ACK) & ~rst;
    assign ram_en   = commit & in_range;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!req)          state_nxt = IDLE;
                else if (cnt == 0) state_nxt = ACK;
                else               cnt_nxt   = cnt - 4'd1;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_adr <= '0;
            lat_we  <= 1'b0;
            lat_dat <= '0;
            rd_zero <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_adr <= data_adr_i;
                lat_we  <= data_we_i;
                lat_dat <= data_dat_i;
            end
            // Out-of-range accesses present zero until the next access.
            if (commit) rd_zero <= ~in_range;
        end
    end

    gumnut_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (acc_we),
        .adr  (acc_adr[IDX_W-1:0]),
        .din  (acc_dat),
        .dout (ram_dout)
    );

    assign data_ack_o = (state == ACK);
    assign data_dat_o = rd_zero ? '0 : ram_dout;
endmodule

// File: tb/tb_gumnut_data_mem_responder.sv
// Self-checking bench: three responders with different wait-state/depth settings
// checked against an array-based memory model and latency = WAIT_STATES + 1.
module tb_gumnut_data_mem_responder;
    localparam int WS_T[3]    = '{0, 1, 3};
    localparam int DEPTH_T[3] = '{256, 128, 256};

    logic clk = 1'b0;
    logic rst;
    logic [2:0]      cyc, stb, we;
    logic [2:0][7:0] adr, din;
    wire  [2:0]      ack;
    wire  [2:0][7:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mdl   [3][256];
    bit         known [3][256];

    always #5 clk = ~clk;

    gumnut_data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[0]), .data_stb_i(stb[0]), .data_we_i(we[0]),
        .data_adr_i(adr[0]), .data_dat_i(din[0]), .data_dat_o(dout[0]), .data_ack_o(ack[0]));
    gumnut_data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[1]), .data_stb_i(stb[1]), .data_we_i(we[1]),
        .data_adr_i(adr[1]), .data_dat_i(din[1]), .data_dat_o(dout[1]), .data_ack_o(ack[1]));
    gumnut_data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u2 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[2]), .data_stb_i(stb[2]), .data_we_i(we[2]),
        .data_adr_i(adr[2]), .data_dat_i(din[2]), .data_dat_o(dout[2]), .data_ack_o(ack[2]));

    // One complete transfer; lat = posedges from request to ack (-1 on timeout).
    task automatic do_xfer(input int d, input bit w, input logic [7:0] a, input logic [7:0] v,
                           output logic [7:0] rd, output int lat);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; din[d] = v;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ack[d]) begin lat = k; break; end
        end
        rd = dout[d];
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++; if (ack[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ack[%0d]: got %b want 0", d, ack[d]); end
            n_cmp++; if (dout[d] !== 8'h00) begin n_bad++; $display("FAIL reset_dat[%0d]: got %h want 00", d, dout[d]); end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] rd; int lat;
        do_xfer(1, 1'b1, 8'h10, 8'h5A, rd, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL basic_wr_lat: got %0d want 2", lat); end
        do_xfer(1, 1'b0, 8'h10, 8'h00, rd, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL basic_rd_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL basic_rd_data: got %h want 5a", rd); end
        do_xfer(1, 1'b1, 8'h10, 8'h66, rd, lat);
        n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL basic_rbw_data: got %h want 5a", rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; int lat;
        logic [7:0] exp_d;
        do_xfer(0, 1'b1, 8'h00, 8'h11, rd, lat);
        do_xfer(0, 1'b1, 8'h01, 8'h22, rd, lat);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (ack[0] !== k[0]) begin n_bad++; $display("FAIL b2b_ack[%0d]: got %b want %b", k, ack[0], k[0]); end
            if (k == 1 || k == 3) begin
                exp_d = (k == 1) ? 8'h11 : 8'h22;
                n_cmp++; if (dout[0] !== exp_d) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, dout[0], exp_d); end
            end
            if (k == 1) adr[0] = 8'h01;
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [7:0] rd; int lat; bit seen;
        do_xfer(2, 1'b1, 8'h20, 8'h00, rd, lat);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'h20; din[2] = 8'hAA;
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (ack[2]) seen = 1'b1;
            if (k == 2) stb[2] = 1'b0;
        end
        cyc[2] = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got 1 want 0"); end
        do_xfer(2, 1'b0, 8'h20, 8'h00, rd, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL abort_rd_lat: got %0d want 4", lat); end
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL abort_rd_data: got %h want 00", rd); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] rd; int lat;
        do_xfer(1, 1'b1, 8'h00, 8'h33, rd, lat);
        do_xfer(1, 1'b1, 8'h80, 8'hFF, rd, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL oor_wr_lat: got %0d want 2", lat); end
        do_xfer(1, 1'b0, 8'h80, 8'h00, rd, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL oor_rd_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL oor_rd_data: got %h want 00", rd); end
        do_xfer(1, 1'b0, 8'h00, 8'h00, rd, lat);
        n_cmp++; if (rd !== 8'h33) begin n_bad++; $display("FAIL oor_alias_data: got %h want 33", rd); end
    endtask

    task automatic test_addr_change();
        logic [7:0] rd; int lat;
        do_xfer(2, 1'b1, 8'h30, 8'hC3, rd, lat);
        do_xfer(2, 1'b1, 8'h31, 8'h3C, rd, lat);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 8'h30; din[2] = 8'h00;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin adr[2] = 8'h31; we[2] = 1'b1; din[2] = 8'hEE; end
            if (ack[2]) begin lat = k; break; end
        end
        rd = dout[2];
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL chg_lat: got %0d want 4", lat); end
        n_cmp++; if (rd !== 8'hC3) begin n_bad++; $display("FAIL chg_data: got %h want c3", rd); end
        do_xfer(2, 1'b0, 8'h31, 8'h00, rd, lat);
        n_cmp++; if (rd !== 8'h3C) begin n_bad++; $display("FAIL chg_no_write: got %h want 3c", rd); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; int lat; bit seen;
        do_xfer(1, 1'b1, 8'h40, 8'h12, rd, lat);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h40; din[1] = 8'h77;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ack[1] !== 1'b0) begin n_bad++; $display("FAIL rstw_ack: got %b want 0", ack[1]); end
        n_cmp++; if (dout[1] !== 8'h00) begin n_bad++; $display("FAIL rstw_dat: got %h want 00", dout[1]); end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (ack[1]) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstw_late_ack: got 1 want 0"); end
        do_xfer(1, 1'b0, 8'h40, 8'h00, rd, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rstw_idle_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== 8'h12) begin n_bad++; $display("FAIL rstw_old_data: got %h want 12", rd); end
        // reset landing on the ACK cycle must keep the committed write
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h41; din[1] = 8'h99;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ack[1]) begin lat = k; break; end
        end
        rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ack[1] !== 1'b0) begin n_bad++; $display("FAIL rsta_ack: got %b want 0", ack[1]); end
        @(negedge clk); rst = 1'b0;
        do_xfer(1, 1'b0, 8'h41, 8'h00, rd, lat);
        n_cmp++; if (rd !== 8'h99) begin n_bad++; $display("FAIL rsta_kept: got %h want 99", rd); end
    endtask

    task automatic test_random();
        logic [7:0] rd, a, v, exp_d;
        int lat;
        bit w, in_rng, chk;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
            for (int n = 0; n < 40; n++) begin
                a = 8'($urandom_range(0, 15));
                if (d == 1 && $urandom_range(0, 1) == 1) a = a + 8'h80;
                w = 1'($urandom_range(0, 1));
                v = 8'($urandom);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                do_xfer(d, w, a, v, rd, lat);
                in_rng = (int'(a) < DEPTH_T[d]);
                n_cmp++; if (lat !== WS_T[d] + 1) begin n_bad++; $display("FAIL rnd_lat[%0d.%0d]: got %0d want %0d", d, n, lat, WS_T[d] + 1); end
                n_cmp++; if (ack[d] !== 1'b0) begin n_bad++; $display("FAIL rnd_ack_width[%0d.%0d]: got %b want 0", d, n, ack[d]); end
                chk = 1'b0; exp_d = 8'h00;
                if (!in_rng && !w) chk = 1'b1;
                else if (in_rng && known[d][a]) begin chk = 1'b1; exp_d = mdl[d][a]; end
                if (chk) begin
                    n_cmp++;
                    if (rd !== exp_d) begin n_bad++; $display("FAIL rnd_data[%0d.%0d] adr %h we %b: got %h want %h", d, n, a, w, rd, exp_d); end
                end
                if (w && in_rng) begin mdl[d][a] = v; known[d][a] = 1'b1; end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cyc = '0; stb = '0; we = '0; adr = '0; din = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_out_of_range();
        test_addr_change();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
